// File: rtl/shift_serializer.sv
// shift_serializer: splits IN_W-bit words into OUT_W-bit slices.
// Storage is a shift register (SR) feeding the output, plus one holding
// register (HR) that keeps slice output contiguous across word boundaries.
// All status outputs are decoded from registered state only.
// Optional feature macro: SHIFT_SERIALIZER_LAST_EN adds out_last, which
// flags the final slice of each word.
module shift_serializer #(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in,
    input  logic             wr,
    output logic             full,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    input  logic             rd,
    output logic             empty,
    output logic             ovf
`ifdef SHIFT_SERIALIZER_LAST_EN
    ,
    output logic             out_last
`endif
);

    localparam int RATIO = IN_W / OUT_W;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    logic [IN_W-1:0]  sr_q, sr_d;
    logic [IN_W-1:0]  hr_q, hr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sr_vld_q, sr_vld_d;
    logic             hr_vld_q, hr_vld_d;
    logic             ovf_q, ovf_d;

    logic consume;
    logic final_consume;
    logic accept;
    logic load_sr;

    // Next-state: consume/shift, HR-to-SR refill, write steering, overflow.
    always_comb begin
        sr_d     = sr_q;
        hr_d     = hr_q;
        cnt_d    = cnt_q;
        sr_vld_d = sr_vld_q;
        hr_vld_d = hr_vld_q;
        ovf_d    = ovf_q;

        consume       = rd & sr_vld_q;
        final_consume = consume & (cnt_q == CNT_LAST);
        accept        = wr & ~hr_vld_q;
        // A new word may bypass HR when SR is idle or is emptying this edge
        // with nothing waiting behind it.
        load_sr       = ~sr_vld_q | (final_consume & ~hr_vld_q);

        if (consume) begin
            if (MSB_FIRST != 0) begin
                sr_d = sr_q << OUT_W;
            end else begin
                sr_d = sr_q >> OUT_W;
            end
            if (final_consume) begin
                cnt_d    = '0;
                sr_vld_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Refill from HR on the final slice so the next word follows
        // without a bubble. accept is blocked while HR is valid, so this
        // never collides with a write.
        if (final_consume && hr_vld_q) begin
            sr_d     = hr_q;
            sr_vld_d = 1'b1;
            cnt_d    = '0;
            hr_vld_d = 1'b0;
        end

        if (accept) begin
            if (load_sr) begin
                sr_d     = in;
                sr_vld_d = 1'b1;
                cnt_d    = '0;
            end else begin
                hr_d     = in;
                hr_vld_d = 1'b1;
            end
        end

        // Write while full: the word is dropped and the flag sticks.
        if (wr && hr_vld_q) begin
            ovf_d = 1'b1;
        end
    end

    // State registers with synchronous reset taking priority over wr/rd.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q     <= '0;
            hr_q     <= '0;
            cnt_q    <= '0;
            sr_vld_q <= 1'b0;
            hr_vld_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            hr_q     <= hr_d;
            cnt_q    <= cnt_d;
            sr_vld_q <= sr_vld_d;
            hr_vld_q <= hr_vld_d;
            ovf_q    <= ovf_d;
        end
    end

    // The output slice always sits at the end of SR nearest the shift exit.
    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign out = sr_q[IN_W-1 -: OUT_W];
        end else begin : g_lsb
            assign out = sr_q[OUT_W-1:0];
        end
    endgenerate

    assign out_valid = sr_vld_q;
    assign full      = hr_vld_q;
    assign empty     = ~(sr_vld_q | hr_vld_q);
    assign ovf       = ovf_q;

`ifdef SHIFT_SERIALIZER_LAST_EN
    assign out_last = sr_vld_q & (cnt_q == CNT_LAST);
`endif

endmodule

// File: tb/tb_shift_serializer.sv
module tb_shift_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic [15:0] in_a = '0;
    logic        wr_a = 1'b0;
    logic        rd_a = 1'b0;
    logic        full_a, out_valid_a, empty_a, ovf_a;
    logic [7:0]  out_a;
`ifdef SHIFT_SERIALIZER_LAST_EN
    logic        last_a;
`endif

    logic [31:0] in_b = '0;
    logic        wr_b = 1'b0;
    logic        rd_b = 1'b0;
    logic        full_b, out_valid_b, empty_b, ovf_b;
    logic [7:0]  out_b;
`ifdef SHIFT_SERIALIZER_LAST_EN
    logic        last_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // status word: {out_valid, out, full, empty, ovf}
    logic [11:0] st_a, st_b;
    assign st_a = {out_valid_a, out_a, full_a, empty_a, ovf_a};
    assign st_b = {out_valid_b, out_b, full_b, empty_b, ovf_b};

    always #5 clk = ~clk;

    shift_serializer #(.IN_W(16), .OUT_W(8), .MSB_FIRST(1)) dut_a (
        .clk(clk), .reset(reset), .in(in_a), .wr(wr_a), .full(full_a),
        .out(out_a), .out_valid(out_valid_a), .rd(rd_a), .empty(empty_a),
        .ovf(ovf_a)
`ifdef SHIFT_SERIALIZER_LAST_EN
        , .out_last(last_a)
`endif
    );

    shift_serializer #(.IN_W(32), .OUT_W(8), .MSB_FIRST(0)) dut_b (
        .clk(clk), .reset(reset), .in(in_b), .wr(wr_b), .full(full_b),
        .out(out_b), .out_valid(out_valid_b), .rd(rd_b), .empty(empty_b),
        .ovf(ovf_b)
`ifdef SHIFT_SERIALIZER_LAST_EN
        , .out_last(last_b)
`endif
    );

    // advance one rising edge; inputs change and outputs are sampled 1 ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (st_a !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL reset_a: got %h expected %h", st_a, {1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
            n_fail++;
        end
        n_checks++;
        if (st_b !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL reset_b: got %h expected %h", st_b, {1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
            n_fail++;
        end
    endtask

    task automatic test_single();
        in_a = 16'hABCD; wr_a = 1'b1; rd_a = 1'b1;
        tick();
        wr_a = 1'b0;
        n_checks++;
        if (st_a !== {1'b1, 8'hAB, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL single_ab: got %h expected %h", st_a, {1'b1, 8'hAB, 1'b0, 1'b0, 1'b0});
            n_fail++;
        end
        tick();
        n_checks++;
        if (st_a !== {1'b1, 8'hCD, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL single_cd: got %h expected %h", st_a, {1'b1, 8'hCD, 1'b0, 1'b0, 1'b0});
            n_fail++;
        end
        tick();
        n_checks++;
        if ({out_valid_a, empty_a} !== 2'b01) begin
            $display("FAIL single_done: got valid/empty %b expected 01", {out_valid_a, empty_a});
            n_fail++;
        end
        rd_a = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_out [4];
        logic       exp_full [4];
        logic       exp_last [4];
        exp_out  = '{8'hAB, 8'hCD, 8'h12, 8'h34};
        exp_full = '{1'b0, 1'b1, 1'b0, 1'b0};
        exp_last = '{1'b0, 1'b1, 1'b0, 1'b1};
        in_a = 16'hABCD; wr_a = 1'b1; rd_a = 1'b1;
        tick();
        in_a = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) wr_a = 1'b0;
            n_checks++;
            if (st_a !== {1'b1, exp_out[i], exp_full[i], 1'b0, 1'b0}) begin
                $display("FAIL b2b_slice%0d: got %h expected %h", i, st_a,
                         {1'b1, exp_out[i], exp_full[i], 1'b0, 1'b0});
                n_fail++;
            end
`ifdef SHIFT_SERIALIZER_LAST_EN
            n_checks++;
            if (last_a !== exp_last[i]) begin
                $display("FAIL b2b_last%0d: got %b expected %b", i, last_a, exp_last[i]);
                n_fail++;
            end
`else
            if (exp_last[i] === 1'bx) $display("unexpected unknown");
`endif
            tick();
        end
        n_checks++;
        if ({out_valid_a, empty_a, ovf_a} !== 3'b010) begin
            $display("FAIL b2b_done: got valid/empty/ovf %b expected 010", {out_valid_a, empty_a, ovf_a});
            n_fail++;
        end
        rd_a = 1'b0;
    endtask

    task automatic test_overflow();
        rd_a = 1'b0;
        in_a = 16'hABCD; wr_a = 1'b1;
        tick();
        in_a = 16'h1234;
        tick();
        n_checks++;
        if (st_a !== {1'b1, 8'hAB, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL ovf_full: got %h expected %h", st_a, {1'b1, 8'hAB, 1'b1, 1'b0, 1'b0});
            n_fail++;
        end
        in_a = 16'h5678;
        tick();
        wr_a = 1'b0;
        n_checks++;
        if (st_a !== {1'b1, 8'hAB, 1'b1, 1'b0, 1'b1}) begin
            $display("FAIL ovf_set: got %h expected %h", st_a, {1'b1, 8'hAB, 1'b1, 1'b0, 1'b1});
            n_fail++;
        end
        tick();
        n_checks++;
        if (st_a !== {1'b1, 8'hAB, 1'b1, 1'b0, 1'b1}) begin
            $display("FAIL ovf_stall: got %h expected %h", st_a, {1'b1, 8'hAB, 1'b1, 1'b0, 1'b1});
            n_fail++;
        end
        rd_a = 1'b1;
        tick();
        n_checks++;
        if (st_a !== {1'b1, 8'hCD, 1'b1, 1'b0, 1'b1}) begin
            $display("FAIL ovf_cd: got %h expected %h", st_a, {1'b1, 8'hCD, 1'b1, 1'b0, 1'b1});
            n_fail++;
        end
        tick();
        n_checks++;
        if (st_a !== {1'b1, 8'h12, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL ovf_12: got %h expected %h", st_a, {1'b1, 8'h12, 1'b0, 1'b0, 1'b1});
            n_fail++;
        end
        tick();
        n_checks++;
        if (st_a !== {1'b1, 8'h34, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL ovf_34: got %h expected %h", st_a, {1'b1, 8'h34, 1'b0, 1'b0, 1'b1});
            n_fail++;
        end
        tick();
        n_checks++;
        if ({out_valid_a, full_a, empty_a, ovf_a} !== 4'b0011) begin
            $display("FAIL ovf_done: got valid/full/empty/ovf %b expected 0011",
                     {out_valid_a, full_a, empty_a, ovf_a});
            n_fail++;
        end
        rd_a = 1'b0;
    endtask

    task automatic test_rd_empty();
        rd_a = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({out_valid_a, full_a, empty_a} !== 3'b001) begin
            $display("FAIL rd_empty: got valid/full/empty %b expected 001", {out_valid_a, full_a, empty_a});
            n_fail++;
        end
        rd_a = 1'b0;
    endtask

    task automatic test_reset_mid_word();
        rd_a = 1'b0;
        in_a = 16'hABCD; wr_a = 1'b1;
        tick();
        in_a = 16'h1234;
        tick();
        in_a = 16'h5678;
        tick();
        wr_a = 1'b0;
        rd_a = 1'b1;
        tick();
        n_checks++;
        if (st_a !== {1'b1, 8'hCD, 1'b1, 1'b0, 1'b1}) begin
            $display("FAIL rstmid_pre: got %h expected %h", st_a, {1'b1, 8'hCD, 1'b1, 1'b0, 1'b1});
            n_fail++;
        end
        reset = 1'b1; wr_a = 1'b1; in_a = 16'h9999;
        tick();
        reset = 1'b0; wr_a = 1'b0;
        n_checks++;
        if (st_a !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL rstmid_post: got %h expected %h", st_a, {1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
            n_fail++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({out_valid_a, empty_a} !== 2'b01) begin
                $display("FAIL rstmid_quiet%0d: got valid/empty %b expected 01", i, {out_valid_a, empty_a});
                n_fail++;
            end
        end
        rd_a = 1'b0;
    endtask

    task automatic test_lsb_first();
        logic [7:0] exp_out [4];
        exp_out = '{8'h44, 8'h33, 8'h22, 8'h11};
        in_b = 32'h11223344; wr_b = 1'b1; rd_b = 1'b1;
        tick();
        wr_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (st_b !== {1'b1, exp_out[i], 1'b0, 1'b0, 1'b0}) begin
                $display("FAIL lsb_slice%0d: got %h expected %h", i, st_b, {1'b1, exp_out[i], 1'b0, 1'b0, 1'b0});
                n_fail++;
            end
`ifdef SHIFT_SERIALIZER_LAST_EN
            n_checks++;
            if (last_b !== (i == 3)) begin
                $display("FAIL lsb_last%0d: got %b expected %b", i, last_b, (i == 3));
                n_fail++;
            end
`endif
            tick();
        end
        n_checks++;
        if ({out_valid_b, empty_b} !== 2'b01) begin
            $display("FAIL lsb_done: got valid/empty %b expected 01", {out_valid_b, empty_b});
            n_fail++;
        end
        rd_b = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset();
        test_rd_empty();
        test_reset_mid_word();
        test_lsb_first();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
